// File: rtl/cdp_pkg.sv
// ----------------------------------------------------------------------------
// cdp_pkg
// Shared definitions for the cdp_arbitro priority encoder / arbiter.
//   MODE_FIXED / MODE_RR : encodings of the run-time arbitration mode input
//   state_t              : grant FSM states (IDLE = no grant, GRANT = grant held)
// ----------------------------------------------------------------------------
package cdp_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage : cdp_pkg

// File: rtl/cdp_rr_search.sv
// ----------------------------------------------------------------------------
// cdp_rr_search
// Combinational downward wrapping search over a request vector.
// Starting at index 'start', walks start, start-1, ..., 0, N-1, ..., start+1
// and reports the first set bit.
//   req   [N-1:0] : request vector
//   start [W-1:0] : first index examined (must be < N)
//   idx   [W-1:0] : index of the first set bit found (0 when none)
//   found         : at least one request bit is set
// Fixed priority is the special case start = N-1.
// ----------------------------------------------------------------------------
module cdp_rr_search #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [W-1:0] pos;

    // NOTE: every signal assigned in always_comb gets a default on entry so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        // k is the search distance from 'start'; the first hit wins because
        // later hits are masked by 'found'.
        for (int k = 0; k < N; k++) begin
            if (int'(start) >= k)
                pos = W'(int'(start) - k);
            else
                pos = W'(int'(start) - k + N);
            if (!found && req[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

endmodule : cdp_rr_search

// File: rtl/cdp_arbitro.sv
// ----------------------------------------------------------------------------
// cdp_arbitro
// Registered N-input priority encoder / arbiter with run-time selectable
// fixed-priority or round-robin mode and a valid/ready grant handshake.
//   clk                : clock, rising edge
//   rst                : asynchronous active-high reset
//   in        [N-1:0]  : request vector, bit i = requester i
//   mode               : 0 = fixed priority (bit N-1 highest), 1 = round-robin
//   ready              : consumer accepts the current grant when valid is high
//   out       [W-1:0]  : index of granted requester
//   onehot    [N-1:0]  : one-hot grant, 1 << out while valid, else 0
//   valid              : grant present
//   req_count [C-1:0]  : registered popcount of in
// A grant is held unchanged until accepted; on acceptance the arbiter
// re-arbitrates on the same edge, so back-to-back grants have no bubble.
// ----------------------------------------------------------------------------
module cdp_arbitro
    import cdp_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N),
    localparam int C = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    input  logic         mode,
    input  logic         ready,
    output logic [W-1:0] out,
    output logic [N-1:0] onehot,
    output logic         valid,
    output logic [C-1:0] req_count
);

    state_t       state;
    logic [W-1:0] ptr;
    logic [W-1:0] ptr_next;
    logic [W-1:0] search_start;
    logic [W-1:0] win_idx;
    logic         win_found;
    logic [N-1:0] onehot_next;
    logic         handshake;

    assign handshake = (state == GRANT) && ready;

    // Round-robin pointer moves to just below the accepted index. The search
    // below uses this post-update value so a same-edge re-arbitration already
    // skips the requester that was just served.
    always_comb begin
        ptr_next = ptr;
        if (handshake && (mode == MODE_RR))
            ptr_next = (out == '0) ? W'(N - 1) : out - 1'b1;
    end

    assign search_start = (mode == MODE_RR) ? ptr_next : W'(N - 1);

    cdp_rr_search #(
        .N (N)
    ) u_search (
        .req   (in),
        .start (search_start),
        .idx   (win_idx),
        .found (win_found)
    );

    always_comb begin
        onehot_next          = '0;
        onehot_next[win_idx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the asynchronous reset clears all outputs immediately, discarding
    // any pending grant; ptr returns to N-1 so round-robin restarts at the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= W'(N - 1);
            out       <= '0;
            onehot    <= '0;
            valid     <= 1'b0;
            req_count <= '0;
        end else begin
            req_count <= C'($countones(in));
            ptr       <= ptr_next;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        out    <= win_idx;
                        onehot <= onehot_next;
                        valid  <= 1'b1;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    // Without ready the grant is frozen, even if its request drops.
                    if (ready) begin
                        if (win_found) begin
                            out    <= win_idx;
                            onehot <= onehot_next;
                        end else begin
                            onehot <= '0;
                            valid  <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: begin
                    onehot <= '0;
                    valid  <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule : cdp_arbitro

// File: tb/tb_cdp_arbitro.sv
// ----------------------------------------------------------------------------
// tb_cdp_arbitro
// Directed self-checking bench for cdp_arbitro with N = 4. Inputs change 1 ns
// after each rising edge; outputs are checked at the same point, after the
// edge that produced them.
// ----------------------------------------------------------------------------
module tb_cdp_arbitro;

    localparam int N = 4;
    localparam int W = $clog2(N);
    localparam int C = $clog2(N + 1);

    logic         clk;
    logic         rst;
    logic [N-1:0] in;
    logic         mode;
    logic         ready;
    logic [W-1:0] out;
    logic [N-1:0] onehot;
    logic         valid;
    logic [C-1:0] req_count;

    int tests;
    int fails;

    cdp_arbitro #(
        .N (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .mode      (mode),
        .ready     (ready),
        .out       (out),
        .onehot    (onehot),
        .valid     (valid),
        .req_count (req_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [W-1:0] exp_out);
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_out"}, 32'(out), 32'(exp_out));
        check({tag, "_onehot"}, 32'(onehot), 32'(4'b0001 << exp_out));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        in    = '0;
        mode  = 1'b0;
        ready = 1'b0;

        // Reset state
        step();
        step();
        check("rst_out", 32'(out), 32'd0);
        check("rst_onehot", 32'(onehot), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_count", 32'(req_count), 32'd0);

        // Fixed priority: 1100 -> 3, stays 3 while accepted each cycle
        rst   = 1'b0;
        mode  = 1'b0;
        in    = 4'b1100;
        ready = 1'b1;
        step();
        check_grant("fix0", 2'd3);
        check("fix0_count", 32'(req_count), 32'd2);
        step();
        check_grant("fix1", 2'd3);
        step();
        check_grant("fix2", 2'd3);

        // Grant of 2, then asynchronous reset mid-grant
        in = 4'b0100;
        step();
        check_grant("pre_rst", 2'd2);
        rst = 1'b1;
        #1;
        check("async_out", 32'(out), 32'd0);
        check("async_onehot", 32'(onehot), 32'd0);
        check("async_valid", 32'(valid), 32'd0);
        check("async_count", 32'(req_count), 32'd0);

        // Round-robin rotation from reset: 3,2,1,0,3,2 without bubbles
        mode  = 1'b1;
        in    = 4'b1111;
        ready = 1'b1;
        #1;
        rst = 1'b0;
        step();
        check_grant("rr0", 2'd3);
        check("rr0_count", 32'(req_count), 32'd4);
        step();
        check_grant("rr1", 2'd2);
        step();
        check_grant("rr2", 2'd1);
        step();
        check_grant("rr3", 2'd0);
        step();
        check_grant("rr4", 2'd3);
        step();
        check_grant("rr5", 2'd2);

        // Backpressure hold after a fresh reset (ptr back at 3)
        rst = 1'b1;
        #1;
        rst   = 1'b0;
        mode  = 1'b1;
        in    = 4'b0110;
        ready = 1'b0;
        step();
        check_grant("hold0", 2'd2);
        in = 4'b0000;
        step();
        check_grant("hold1", 2'd2);
        step();
        check_grant("hold2", 2'd2);
        step();
        check_grant("hold3", 2'd2);
        check("hold3_count", 32'(req_count), 32'd0);
        ready = 1'b1;
        step();
        check("drain_valid", 32'(valid), 32'd0);
        check("drain_onehot", 32'(onehot), 32'd0);

        // Wrap-around: ptr is 1 after accepting 2; 0001 -> grant 0
        ready = 1'b0;
        in    = 4'b0001;
        step();
        check_grant("wrap0", 2'd0);
        ready = 1'b1;
        step();
        check_grant("wrap1", 2'd0);
        // Accepting 0 wraps ptr to 3, so 1001 now grants 3
        in = 4'b1001;
        step();
        check_grant("wrap2", 2'd3);

        // Popcount; accepting 3 moves ptr to 2, search 2,1 -> 1
        in = 4'b1011;
        step();
        check("pop_count3", 32'(req_count), 32'd3);
        check_grant("pop_grant", 2'd1);
        in = 4'b0000;
        step();
        check("pop_count0", 32'(req_count), 32'd0);
        check("pop_valid", 32'(valid), 32'd0);
        check("pop_onehot", 32'(onehot), 32'd0);

        // Fixed mode ignores ptr (now 0): 0011 -> 1
        mode = 1'b0;
        in   = 4'b0011;
        step();
        check_grant("fix_after_rr", 2'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_cdp_arbitro

// File: doc/cdp_arbitro.md
# cdp_arbitro

Parametrised, registered priority encoder / arbiter generalising the 4-input priority encoder to N requesters. Encodes the winning request into a binary index and a one-hot grant, and selects fixed-priority or round-robin mode at run time. A valid/ready handshake holds each grant stable until a downstream consumer accepts it. Sits between request sources and any consumer that serves one requester at a time.

## Interface
- N, default 8, number of request lines (legal range N >= 2).
- W, localparam $clog2(N), index width (derived; never overridden).
- C, localparam $clog2(N+1), request-count width (derived).
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in  input  N  request vector, bit i = requester i.
- mode  input  1  0 = fixed priority, 1 = round-robin; sampled at each arbitration edge.
- ready  input  1  consumer accepts current grant when high with valid high.
- out  output  W  index of granted requester.
- onehot  output  N  one-hot grant, equals 1 << out when valid, else 0.
- valid  output  1  grant present.
- req_count  output  C  registered popcount of in.

## Operation
- Fixed mode: highest set index wins (bit N-1 highest priority).
- Round-robin mode: search starts at index ptr, proceeds downward, wraps from 0 to N-1; first set bit wins.
- ptr: W-bit register, reset N-1, so the first round-robin grant matches fixed mode.
- ptr updates only on an accepted handshake in mode 1: ptr <= (g == 0) ? N-1 : g-1, where g = accepted index.
- ptr is not touched in mode 0. A mode change does not reset ptr.
- State IDLE (valid=0): on a clock edge with |in, load the winner into out/onehot and go to GRANT. Otherwise stay in IDLE.
- State GRANT (valid=1), clock edge with ready=1 (handshake):
  - If |in: rearbitrate on the same edge using the post-update ptr and stay in GRANT.
  - Otherwise go to IDLE.
- State GRANT, clock edge with ready=0:
  - out, onehot and valid are held unchanged, even if in changes or the granted bit drops.
  - No rearbitration.
- req_count <= popcount(in) on every edge, independent of state.
- Reset values: out=0, onehot=0, valid=0, req_count=0, ptr=N-1, state IDLE.
- rst asserted mid-grant: all outputs clear asynchronously and the pending grant is discarded.

## Timing
- Request-to-valid latency: 1 cycle. in sampled at edge k; out and valid visible after edge k.
- Handshake completes on the edge where valid=1 and ready=1.
- Back-to-back handshakes: one grant per cycle, no bubble.
- req_count latency: 1 cycle.
- No combinational path from in or ready to any output.
- Reset deassertion: first grant at the earliest on the first edge after rst falls.

## Structure
- Package cdp_pkg holds:
  - mode encodings MODE_FIXED=1'b0, MODE_RR=1'b1;
  - state enum {IDLE, GRANT}.
- Sub-module cdp_rr_search (combinational):
  - inputs req[N-1:0], start[W-1:0];
  - outputs idx[W-1:0], found.
  - Performs the downward wrapping search.
- Fixed mode reuses cdp_rr_search with start=N-1. The top level holds the registers and the FSM.

## Test plan
All scenarios use N=4.
- Reset: rst=1 while valid=1, out=2 -> out=0, onehot=0000, valid=0, req_count=0 immediately. After release, mode=1, in=1111 -> first out=3.
- Fixed priority: mode=0, in=1100, ready=1 held -> valid=1, out=3, onehot=1000 one cycle later. out stays 3 every cycle.
- Round-robin rotation: mode=1, in=1111, ready=1 continuous from reset -> out sequence 3,2,1,0,3,2, valid=1 throughout with no bubble.
- Hold under backpressure:
  - mode=1, in=0110, ready=0 -> out=2, valid=1.
  - Then in=0000 for 3 cycles -> out=2 and valid=1 still held.
  - Then ready=1 for one edge -> valid=0 on the next cycle.
- Wrap-around: mode=1, grant out=0 accepted with in=0001, then in=1001 -> next out=3 (ptr wrapped to 3).
- Popcount: in=1011 -> req_count=3 one cycle later. in=0000 -> req_count=0, and valid=0 after any pending grant is accepted.
